raiz_ctrl: RTL

RAIZ_CTRL -- requirements
Module: raiz_ctrl

---
 rtl/raiz_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/raiz_ctrl.sv
// Sequencing controller for a restoring square-root datapath.
// Issues load/shift/add strobes and counts root-bit iterations down to zero.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for init; all strobes low, iter holds its last value
// LOAD  | clear root and load radicand into the datapath
// SHIFT | move the next two radicand bits into the remainder
// CHECK | trial remainder settles; neg selects restore or commit
// ADD   | commit trial remainder and set the root LSB
// NEXT  | count the iteration off; finish or start the next one
// DONE  | one-cycle completion pulse, then back to IDLE
module raiz_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  neg,
  output logic                  load,
  output logic                  shift,
  output logic                  add,
  output logic                  busy,
  output logic                  done,
  output logic [$clog2(ITER):0] iter
);

  localparam int IW = $clog2(ITER) + 1;
  localparam logic [IW-1:0] ITER_INIT = IW'(ITER);
  localparam logic [IW-1:0] ONE       = IW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    ADD   = 3'd4,
    NEXT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state;

  // Outputs are registered alongside the state so they reflect the state
  // being entered and stay flat for the whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
      load  <= 1'b0;
      shift <= 1'b0;
      add   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      load  <= 1'b0;
      shift <= 1'b0;
      add   <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b1;
      case (state)
        IDLE: begin
          if (init) begin
            state <= LOAD;
            load  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          iter  <= ITER_INIT;
          state <= SHIFT;
          shift <= 1'b1;
        end
        SHIFT: begin
          state <= CHECK;
        end
        CHECK: begin
          if (neg) begin
            state <= NEXT;
          end else begin
            state <= ADD;
            add   <= 1'b1;
          end
        end
        ADD: begin
          state <= NEXT;
        end
        NEXT: begin
          // iter of 0 can only appear after a corrupted count; treat it as
          // the last iteration rather than wrapping.
          if (iter <= ONE) begin
            iter  <= '0;
            state <= DONE;
            done  <= 1'b1;
          end else begin
            iter  <= iter - ONE;
            state <= SHIFT;
            shift <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
